fetch_wipe_stage: RTL and testbench

//  Registered, parametrised successor to the frontend instruction wiper. Takes one fetch

---
 rtl/frontend_pkg.sv | 27 ++
 rtl/fetch_wipe_buf.sv | 65 ++++++
 rtl/fetch_wipe_stage.sv | 128 ++++++++++++
 tb/tb_fetch_wipe_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// -----------------------------------------------------------------------------
// frontend_pkg
// Shared frontend constants and the wiped fetch-block record that travels from
// the fetch wipe stage into the instruction buffer.
//   FETCH_NUM_INSTS : instruction slots per fetch block
//   FETCH_INST_W    : bits per instruction slot
//   FETCH_PC_W      : program counter width
//   INST_BYTES      : bytes covered by one slot
//   BLOCK_OFF_W     : byte-offset bits inside one fetch block
//   fetch_blk_t     : wiped data, live-slot mask, next fetch PC, ignored-prediction flag
// -----------------------------------------------------------------------------
package frontend_pkg;

  localparam int FETCH_NUM_INSTS = 16;
  localparam int FETCH_INST_W    = 32;
  localparam int FETCH_PC_W      = 64;
  localparam int INST_BYTES      = 4;
  localparam int BLOCK_OFF_W     = $clog2(FETCH_NUM_INSTS * INST_BYTES);

  typedef struct packed {
    logic [FETCH_NUM_INSTS*FETCH_INST_W-1:0] data;
    logic [FETCH_NUM_INSTS-1:0]              slot_valid;
    logic [FETCH_PC_W-1:0]                   next_pc;
    logic                                    pred_oob;
  } fetch_blk_t;

endpackage

// File: rtl/fetch_wipe_buf.sv
// -----------------------------------------------------------------------------
// fetch_wipe_buf
// Generic two-entry valid/ready FIFO with a synchronous flush.
//   clock, reset_n       : clock, asynchronous active-low reset
//   flush                : empties the FIFO at the next edge, beats push and pop
//   in_valid / in_ready  : producer handshake; in_ready comes straight off the
//                          occupancy register (no path from out_ready)
//   in_data              : WIDTH-bit payload
//   out_valid / out_ready: consumer handshake, head entry drives out_data
//   out_data             : head payload (all zeros after reset)
// -----------------------------------------------------------------------------
module fetch_wipe_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = ~count[1];
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values. The storage array is reset on purpose here: the head is
  // visible on out_data and must read as zero straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_wipe_stage.sv
// -----------------------------------------------------------------------------
// fetch_wipe_stage
// Wipes one fetch block against its entry PC and taken-branch prediction, then
// holds the result in a two-entry buffer (latency 1 from accept to out_*).
//   clock, reset_n  : clock, asynchronous active-low reset
//   flush           : redirect, drops held and incoming blocks
//   in_valid/in_ready, in_data, in_base_pc, in_pred_taken, in_trigger_pc,
//   in_target_pc    : incoming block and its prediction
//   out_valid/out_ready, out_data, out_slot_valid, out_next_pc, out_pred_oob :
//                     wiped block at the buffer head
// Build option FETCH_WIPE_PERF_EN adds saturating counters perf_wiped_blks
// (accepted blocks whose tail was cut by a prediction) and perf_oob_cnt
// (accepted blocks whose prediction was ignored); flush does not clear them.
// -----------------------------------------------------------------------------
module fetch_wipe_stage #(
  parameter int NUM_INSTS  = frontend_pkg::FETCH_NUM_INSTS,
  parameter int INST_W     = frontend_pkg::FETCH_INST_W,
  parameter int PC_W       = frontend_pkg::FETCH_PC_W,
  parameter int INST_BYTES = frontend_pkg::INST_BYTES
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INSTS*INST_W-1:0] in_data,
  input  logic [PC_W-1:0]             in_base_pc,
  input  logic                        in_pred_taken,
  input  logic [PC_W-1:0]             in_trigger_pc,
  input  logic [PC_W-1:0]             in_target_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_INSTS*INST_W-1:0] out_data,
  output logic [NUM_INSTS-1:0]        out_slot_valid,
  output logic [PC_W-1:0]             out_next_pc,
  output logic                        out_pred_oob
`ifdef FETCH_WIPE_PERF_EN
  ,
  output logic [31:0]                 perf_wiped_blks,
  output logic [31:0]                 perf_oob_cnt
`endif
);

  localparam int BLOCK_BYTES = NUM_INSTS * INST_BYTES;
  localparam int OFF_W       = $clog2(BLOCK_BYTES);
  localparam int IB_W        = $clog2(INST_BYTES);
  localparam int SLOT_W      = OFF_W - IB_W;

  // Same layout as frontend_pkg::fetch_blk_t, sized by this instance's parameters.
  typedef struct packed {
    logic [NUM_INSTS*INST_W-1:0] data;
    logic [NUM_INSTS-1:0]        slot_valid;
    logic [PC_W-1:0]             next_pc;
    logic                        pred_oob;
  } blk_t;

  logic [PC_W-1:0]   blk_pc;
  logic [PC_W-1:0]   diff;
  logic [SLOT_W-1:0] start_slot;
  logic [SLOT_W-1:0] trig_slot;
  logic              in_range;
  logic              aligned;
  logic              pred_ok;
  blk_t              wiped;
  blk_t              head;

  assign blk_pc     = in_base_pc & ~PC_W'(BLOCK_BYTES - 1);
  assign start_slot = in_base_pc[OFF_W-1:IB_W];
  assign diff       = in_trigger_pc - blk_pc;
  // Only meaningful when in_range holds; pred_ok is gated accordingly.
  assign trig_slot  = diff[OFF_W-1:IB_W];
  assign in_range   = diff < PC_W'(BLOCK_BYTES);
  assign aligned    = (diff & PC_W'(INST_BYTES - 1)) == '0;
  // A trigger before the entry slot can never be reached, so it is ignored.
  assign pred_ok    = in_pred_taken & in_range & aligned & (trig_slot >= start_slot);

  always_comb begin
    // NOTE: full default first so no path through this block can infer a latch.
    wiped = '0;
    for (int i = 0; i < NUM_INSTS; i++) begin
      wiped.slot_valid[i] = (SLOT_W'(i) >= start_slot) && (!pred_ok || (SLOT_W'(i) <= trig_slot));
      if (wiped.slot_valid[i]) begin
        wiped.data[i*INST_W +: INST_W] = in_data[i*INST_W +: INST_W];
      end
    end
    wiped.next_pc  = pred_ok ? in_target_pc : blk_pc + PC_W'(BLOCK_BYTES);
    wiped.pred_oob = in_pred_taken & ~pred_ok;
  end

  fetch_wipe_buf #(
    .WIDTH($bits(blk_t))
  ) u_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (wiped),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out_data       = head.data;
  assign out_slot_valid = head.slot_valid;
  assign out_next_pc    = head.next_pc;
  assign out_pred_oob   = head.pred_oob;

`ifdef FETCH_WIPE_PERF_EN
  logic push_fire;
  assign push_fire = in_valid & in_ready & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_wiped_blks <= '0;
      perf_oob_cnt    <= '0;
    end else begin
      if (push_fire && pred_ok && (trig_slot < SLOT_W'(NUM_INSTS - 1)) && (perf_wiped_blks != '1)) begin
        perf_wiped_blks <= perf_wiped_blks + 32'd1;
      end
      if (push_fire && wiped.pred_oob && (perf_oob_cnt != '1)) begin
        perf_oob_cnt <= perf_oob_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_wipe_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_wipe_stage
// Self-checking bench for fetch_wipe_stage (default parameters). A behavioural
// model derives each wiped block from PC arithmetic and a queue stands in for
// the two-entry buffer; outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_wipe_stage;

  localparam int N  = 16;
  localparam int IW = 32;
  localparam int PW = 64;
  localparam int DW = N * IW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_base_pc = '0;
  logic          in_pred_taken = 1'b0;
  logic [PW-1:0] in_trigger_pc = '0;
  logic [PW-1:0] in_target_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_slot_valid;
  logic [PW-1:0] out_next_pc;
  logic          out_pred_oob;
`ifdef FETCH_WIPE_PERF_EN
  logic [31:0]   perf_wiped_blks;
  logic [31:0]   perf_oob_cnt;
`endif

  fetch_wipe_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_base_pc    (in_base_pc),
    .in_pred_taken (in_pred_taken),
    .in_trigger_pc (in_trigger_pc),
    .in_target_pc  (in_target_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_slot_valid(out_slot_valid),
    .out_next_pc   (out_next_pc),
    .out_pred_oob  (out_pred_oob)
`ifdef FETCH_WIPE_PERF_EN
    ,
    .perf_wiped_blks(perf_wiped_blks),
    .perf_oob_cnt   (perf_oob_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  mask;
    logic [PW-1:0] npc;
    logic          oob;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wipe rule stated on byte addresses: a 64-byte block of 4-byte slots.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [PW-1:0] base,
                                 input logic taken, input logic [PW-1:0] trig,
                                 input logic [PW-1:0] tgt);
    exp_t          e;
    logic [PW-1:0] blk;
    logic [PW-1:0] start;
    logic [PW-1:0] diff;
    bit            ok;
    blk   = base - (base % 64);
    start = (base % 64) / 4;
    diff  = trig - blk;
    ok    = taken && (diff < 64) && (diff % 4 == 0) && (diff / 4 >= start);
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < N; i++) begin
      if ((64'(i) >= start) && (!ok || (64'(i) <= diff / 4))) begin
        e.mask[i] = 1'b1;
        e.data[i*IW +: IW] = d[i*IW +: IW];
      end
    end
    e.npc = ok ? tgt : blk + 64;
    e.oob = taken && !ok;
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*IW +: IW] = $urandom;
    return d;
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_slot_valid", out_slot_valid, q[0].mask);
      check("out_next_pc", out_next_pc, q[0].npc);
      check("out_pred_oob", out_pred_oob, q[0].oob);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_slot_valid"}, out_slot_valid, '0);
    check({tag, "_out_next_pc"}, out_next_pc, '0);
    check({tag, "_out_pred_oob"}, out_pred_oob, 1'b0);
  endtask

  // Drive one cycle of inputs, advance the reference, then compare at the next falling edge.
  task automatic cycle(input logic v, input logic [PW-1:0] base, input logic taken,
                       input logic [PW-1:0] trig, input logic [PW-1:0] tgt,
                       input logic [DW-1:0] d, input logic ordy, input logic fl);
    bit push;
    bit pop;
    in_valid      = v;
    in_base_pc    = base;
    in_pred_taken = taken;
    in_trigger_pc = trig;
    in_target_pc  = tgt;
    in_data       = d;
    out_ready     = ordy;
    flush         = fl;
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && ordy && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model(d, base, taken, trig, tgt));
    end
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  logic [DW-1:0] d;
  logic [DW-1:0] lo_mask;
  logic [PW-1:0] base;
  logic [PW-1:0] trig;
  logic [PW-1:0] blk;

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    compare_all();

    // Not taken: whole block live, next PC is the following block.
    d = rand_data();
    cycle(1'b1, 64'h1000, 1'b0, 64'h0, 64'h0, d, 1'b1, 1'b0);
    check("t1_mask", out_slot_valid, 16'hFFFF);
    check("t1_next", out_next_pc, 64'h1040);
    check("t1_data", out_data, d);
    check("t1_oob", out_pred_oob, 1'b0);

    // Taken at slot 4: slots 5..15 wiped. Pushed while the previous block pops.
    d = rand_data();
    lo_mask = '0;
    for (int i = 0; i < 160; i++) lo_mask[i] = 1'b1;
    cycle(1'b1, 64'h1000, 1'b1, 64'h1010, 64'h2000, d, 1'b1, 1'b0);
    check("t2_mask", out_slot_valid, 16'h001F);
    check("t2_next", out_next_pc, 64'h2000);
    check("t2_data", out_data, d & lo_mask);

    // Trigger before the entry slot: ignored.
    cycle(1'b1, 64'h1008, 1'b1, 64'h1004, 64'h5000, rand_data(), 1'b1, 1'b0);
    check("t3_oob", out_pred_oob, 1'b1);
    check("t3_mask", out_slot_valid, 16'hFFFC);
    check("t3_next", out_next_pc, 64'h1040);

    // Trigger beyond the block: ignored.
    cycle(1'b1, 64'h1008, 1'b1, 64'h1050, 64'h5000, rand_data(), 1'b1, 1'b0);
    check("t4_oob", out_pred_oob, 1'b1);
    check("t4_mask", out_slot_valid, 16'hFFFC);

    // Entry and trigger both on the last slot.
    cycle(1'b1, 64'h103C, 1'b1, 64'h103C, 64'h3000, rand_data(), 1'b1, 1'b0);
    check("t5_mask", out_slot_valid, 16'h8000);
    check("t5_next", out_next_pc, 64'h3000);
    check("t5_oob", out_pred_oob, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the buffer, C waits and then drains in order.
    cycle(1'b1, 64'h100, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b0);
    cycle(1'b1, 64'h200, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b0);
    check("bp_full_ready", in_ready, 1'b0);
    cycle(1'b1, 64'h300, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b0);
    check("bp_held_ready", in_ready, 1'b0);
    check("bp_head_a", out_next_pc, 64'h140);
    cycle(1'b1, 64'h300, 1'b0, 64'h0, 64'h0, rand_data(), 1'b1, 1'b0);
    check("bp_head_b", out_next_pc, 64'h240);
    cycle(1'b1, 64'h300, 1'b0, 64'h0, 64'h0, rand_data(), 1'b1, 1'b0);
    check("bp_head_c", out_next_pc, 64'h340);
    cycle(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, '0, 1'b1, 1'b0);
    check("bp_drained", out_valid, 1'b0);

    // Flush with two held and a new block offered: everything dropped.
    cycle(1'b1, 64'h400, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b0);
    cycle(1'b1, 64'h500, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b0);
    cycle(1'b1, 64'h600, 1'b0, 64'h0, 64'h0, rand_data(), 1'b0, 1'b1);
    check("fl_valid", out_valid, 1'b0);
    check("fl_ready", in_ready, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, '0, 1'b1, 1'b0);
    check("fl_dropped", out_valid, 1'b0);

    // Randomised traffic, with one asynchronous reset in the middle.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        in_valid = 1'b1;
        reset_n  = 1'b0;
        #1;
        check_reset_values("midreset");
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
      end
      base = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) base = 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(0, 63));
      blk = base & ~64'h3F;
      case ($urandom_range(0, 2))
        0:       trig = blk + 64'($urandom_range(0, 15) * 4);
        1:       trig = blk + 64'($urandom_range(0, 80));
        default: trig = {$urandom, $urandom};
      endcase
      cycle($urandom_range(0, 3) != 0, base, $urandom_range(0, 2) != 0, trig,
            {$urandom, $urandom}, rand_data(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
